// File: rtl/mgr_stu_ingress_buffer.sv
// mgr_stu_ingress_buffer: FWFT ingress FIFO with complete-message counting.
// Define MGR_STU_INGRESS_FRAME_CHECK_EN to drop misframed beats and report framing errors.
module mgr_stu_ingress_buffer #(
  parameter int DEPTH  = 16,
  parameter int CNTL_W = 2,
  parameter int TYPE_W = 2,
  parameter int DATA_W = 64,
  parameter int OOB_W  = 32
) (
  input  logic                        clk,
  input  logic                        reset_poweron,
  input  logic                        stu__buf__valid,
  input  logic [CNTL_W-1:0]           stu__buf__cntl,
  input  logic [TYPE_W-1:0]           stu__buf__type,
  input  logic [DATA_W-1:0]           stu__buf__data,
  input  logic [OOB_W-1:0]            stu__buf__oob_data,
  output logic                        buf__stu__ready,
  output logic                        stu__mgr__valid,
  output logic [CNTL_W-1:0]           stu__mgr__cntl,
  output logic [TYPE_W-1:0]           stu__mgr__type,
  output logic [DATA_W-1:0]           stu__mgr__data,
  output logic [OOB_W-1:0]            stu__mgr__oob_data,
  input  logic                        mgr__stu__ready,
  output logic                        buf__mgr__msg_avail,
  output logic [$clog2(DEPTH):0]      buf__mgr__msg_count,
  output logic                        buf__sys__frame_err,
  output logic [7:0]                  buf__sys__frame_err_count
);
  localparam int AW = $clog2(DEPTH);
  logic [CNTL_W-1:0] cntl_mem [DEPTH];
  logic [TYPE_W-1:0] type_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [OOB_W-1:0]  oob_mem  [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ, msg_count;
  logic push, pop, write, viol;
  assign buf__stu__ready     = occ != (AW+1)'(DEPTH);
  assign stu__mgr__valid     = occ != '0;
  assign push                = stu__buf__valid && buf__stu__ready;
  assign pop                 = stu__mgr__valid && mgr__stu__ready;
  assign write               = push && !viol;
  // Storage is not reset, so the head is masked while empty
  assign stu__mgr__cntl      = stu__mgr__valid ? cntl_mem[rd_ptr] : '0;
  assign stu__mgr__type      = stu__mgr__valid ? type_mem[rd_ptr] : '0;
  assign stu__mgr__data      = stu__mgr__valid ? data_mem[rd_ptr] : '0;
  assign stu__mgr__oob_data  = stu__mgr__valid ? oob_mem[rd_ptr]  : '0;
  assign buf__mgr__msg_count = msg_count;
  assign buf__mgr__msg_avail = msg_count != '0;
  always_ff @(posedge clk) begin
    if (write) begin
      cntl_mem[wr_ptr] <= stu__buf__cntl;
      type_mem[wr_ptr] <= stu__buf__type;
      data_mem[wr_ptr] <= stu__buf__data;
      oob_mem[wr_ptr]  <= stu__buf__oob_data;
    end
  end
  // cntl bit 1 marks the last beat of a message (EOM or SOM_EOM)
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      msg_count <= '0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(write);
      rd_ptr    <= rd_ptr + AW'(pop);
      occ       <= occ + (AW+1)'(write) - (AW+1)'(pop);
      msg_count <= msg_count + (AW+1)'(write && stu__buf__cntl[1]) - (AW+1)'(pop && stu__mgr__cntl[1]);
    end
  end
`ifdef MGR_STU_INGRESS_FRAME_CHECK_EN
  typedef enum logic {IDLE, IN_MSG} frame_t;
  frame_t     state;
  logic       err;
  logic [7:0] err_count;
  // cntl bit 0 marks a start: required in IDLE, forbidden inside a message
  assign viol                      = (state == IN_MSG) == stu__buf__cntl[0];
  assign buf__sys__frame_err       = err;
  assign buf__sys__frame_err_count = err_count;
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state     <= IDLE;
      err       <= 1'b0;
      err_count <= '0;
    end else if (push && viol) begin
      err       <= 1'b1;
      err_count <= err_count == 8'hFF ? err_count : err_count + 8'd1;
    end else if (push) begin
      state <= stu__buf__cntl == CNTL_W'(1) ? IN_MSG : stu__buf__cntl == CNTL_W'(2) ? IDLE : state;
    end
  end
`else
  assign viol                      = 1'b0;
  assign buf__sys__frame_err       = 1'b0;
  assign buf__sys__frame_err_count = '0;
`endif
endmodule

// File: tb/tb_mgr_stu_ingress_buffer.sv
// tb_mgr_stu_ingress_buffer: directed stimulus checked every cycle against a queue model.
module tb_mgr_stu_ingress_buffer;
  localparam int DEPTH = 16;
  localparam logic [1:0] MOM = 2'b00, SOM = 2'b01, EOM = 2'b10, SE = 2'b11;
  typedef struct {
    logic [1:0]  c;
    logic [1:0]  t;
    logic [63:0] d;
    logic [31:0] o;
  } beat_t;
  logic clk = 0, reset_poweron = 1;
  logic s_valid = 0, m_ready = 0;
  logic [1:0] s_cntl = 0, s_type = 0;
  logic [63:0] s_data = 0;
  logic [31:0] s_oob = 0;
  logic ready, valid, avail, ferr;
  logic [1:0] h_cntl, h_type;
  logic [63:0] h_data;
  logic [31:0] h_oob;
  logic [4:0] mcount;
  logic [7:0] ecount;
  int checks = 0, errors = 0, pops_seen = 0;
  bit armed = 0;
  beat_t q[$];
  int m_err = 0;
  bit m_ferr = 0, m_in = 0;

  mgr_stu_ingress_buffer dut (
    .clk(clk), .reset_poweron(reset_poweron),
    .stu__buf__valid(s_valid), .stu__buf__cntl(s_cntl), .stu__buf__type(s_type),
    .stu__buf__data(s_data), .stu__buf__oob_data(s_oob), .buf__stu__ready(ready),
    .stu__mgr__valid(valid), .stu__mgr__cntl(h_cntl), .stu__mgr__type(h_type),
    .stu__mgr__data(h_data), .stu__mgr__oob_data(h_oob), .mgr__stu__ready(m_ready),
    .buf__mgr__msg_avail(avail), .buf__mgr__msg_count(mcount),
    .buf__sys__frame_err(ferr), .buf__sys__frame_err_count(ecount)
  );

  always #5 clk = ~clk;

  task automatic check(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic int eoms();
    int n = 0;
    foreach (q[i]) if (q[i].c == EOM || q[i].c == SE) n++;
    return n;
  endfunction

  // Model: the FIFO is a queue; frame state is whether a message is open
  always @(posedge clk) begin
    bit do_push, do_pop, keep;
    if (reset_poweron) begin
      q.delete();
      m_err = 0;
      m_ferr = 0;
      m_in = 0;
    end else begin
      do_pop = q.size() != 0 && m_ready;
      do_push = s_valid && q.size() < DEPTH;
      keep = 1;
`ifdef MGR_STU_INGRESS_FRAME_CHECK_EN
      if (do_push) begin
        if (m_in ? (s_cntl == SOM || s_cntl == SE) : (s_cntl == MOM || s_cntl == EOM)) begin
          keep = 0;
          m_ferr = 1;
          if (m_err < 255) m_err++;
        end else if (s_cntl == SOM) m_in = 1;
        else if (s_cntl == EOM) m_in = 0;
      end
`endif
      if (do_pop) void'(q.pop_front());
      if (do_push && keep) q.push_back('{s_cntl, s_type, s_data, s_oob});
    end
  end

  always @(posedge clk) if (!reset_poweron && valid && m_ready) pops_seen++;

  always @(negedge clk) if (armed) begin
    bit ev;
    ev = q.size() != 0;
    check("ready", ready, q.size() != DEPTH);
    check("valid", valid, ev);
    check("cntl", h_cntl, ev ? q[0].c : 2'b0);
    check("type", h_type, ev ? q[0].t : 2'b0);
    check("data", h_data, ev ? q[0].d : 64'h0);
    check("oob", h_oob, ev ? q[0].o : 32'h0);
    check("msg_count", mcount, eoms());
    check("msg_avail", avail, eoms() != 0);
    check("frame_err", ferr, m_ferr);
    check("frame_err_count", ecount, m_err);
  end

  task automatic step(bit v, logic [1:0] c, logic [63:0] d, bit r);
    s_valid = v;
    s_cntl = c;
    s_type = d[1:0];
    s_data = d;
    s_oob = d[31:0] ^ 32'h5A5A_0F0F;
    m_ready = r;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && valid; i++) step(0, MOM, 0, 1);
    check("drained", valid, 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    armed = 1;
    reset_poweron = 0;
    check("rst ready", ready, 1);
    check("rst valid", valid, 0);
    check("rst count", mcount, 0);
    // single SOM_EOM beat
    step(1, SE, 64'hA5, 0);
    check("t1 valid", valid, 1);
    check("t1 data", h_data, 64'hA5);
    check("t1 count", mcount, 1);
    check("t1 avail", avail, 1);
    step(0, MOM, 0, 1);
    check("t1 pop valid", valid, 0);
    check("t1 pop count", mcount, 0);
    // fill to DEPTH with one 16-beat message
    for (int i = 0; i < 16; i++) step(1, i == 0 ? SOM : i == 15 ? EOM : MOM, 64'h100 + i, 0);
    check("t2 full ready", ready, 0);
    check("t2 count", mcount, 1);
    step(1, SE, 64'hDEAD, 0);
    check("t2 17th ready", ready, 0);
    check("t2 17th count", mcount, 1);
    check("t2 head", h_data, 64'h100);
    step(0, MOM, 0, 1);
    check("t2 ready after pop", ready, 1);
    check("t2 new head", h_data, 64'h101);
    drain();
    // streaming: 10 messages of 10 beats
    pops_seen = 0;
    for (int m = 0; m < 10; m++)
      for (int b = 0; b < 10; b++) step(1, b == 0 ? SOM : b == 9 ? EOM : MOM, 64'(m * 100 + b), 1);
    step(0, MOM, 0, 1);
    check("t3 pops", pops_seen, 100);
    check("t3 empty", valid, 0);
    check("t3 count", mcount, 0);
    // MOM while idle
    step(1, MOM, 64'h77, 0);
`ifdef MGR_STU_INGRESS_FRAME_CHECK_EN
    check("t4 dropped", valid, 0);
    check("t4 err", ferr, 1);
    check("t4 err count", ecount, 1);
    for (int i = 0; i < 300; i++) step(1, MOM, 64'(i), 0);
    check("t4 saturated", ecount, 255);
    check("t4 still empty", valid, 0);
`else
    check("t4 stored", valid, 1);
    check("t4 data", h_data, 64'h77);
    check("t4 no err", ferr, 0);
    drain();
`endif
    // reset with 5 beats buffered mid-message
    for (int i = 0; i < 5; i++) step(1, i == 0 ? SOM : MOM, 64'h200 + i, 0);
    check("t5 head", h_data, 64'h200);
    reset_poweron = 1;
    step(1, MOM, 64'h999, 1);
    reset_poweron = 0;
    check("t5 valid", valid, 0);
    check("t5 ready", ready, 1);
    check("t5 count", mcount, 0);
    check("t5 err cleared", ferr, 0);
    step(1, MOM, 64'h300, 0);
`ifdef MGR_STU_INGRESS_FRAME_CHECK_EN
    check("t5 idle mom err", ferr, 1);
    check("t5 idle mom count", ecount, 1);
    check("t5 idle mom dropped", valid, 0);
`else
    check("t5 mom stored", h_data, 64'h300);
`endif
    step(0, MOM, 0, 1);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
